rb_interp_5x5_pipe: RTL and testbench

- Pipelined, parametrised 5x5 Bayer colour-interpolation kernel for the demosaic datapath.
- Computes one missing colour sample per window using the gradient-corrected 5x5 kernels (coefficients /16).
- Covers four kernel modes, selected per window; generalises the fixed single-case R-at-B combinational kernels.
- Sits between the 5x5 window generator and the RGB packer; valid/ready on both sides; exact full-precision sum with single final rounding, not per-term truncation.

---
 rtl/rb_interp_5x5_pipe.sv | 108 ++++++++++
 tb/tb_rb_interp_5x5_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_interp_5x5_pipe.sv
// Gradient-corrected 5x5 Bayer interpolation kernel, three register stages, valid/ready flow control.
// Computes one missing colour sample per window, with the kernel chosen per window by in_mode.
module rb_interp_5x5_pipe #(
   parameter int DW    = 10,
   parameter int ROUND = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [25*DW-1:0] in_win,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_pix,
   output logic             out_sat
);
   localparam int AW = DW + 6;
   localparam logic signed [AW-1:0] RND_OFS = {{(AW-4){1'b0}}, (ROUND != 0), 3'b000};
   localparam logic signed [AW-1:0] PIX_MAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};

   function automatic logic signed [AW-1:0] tap(input logic [25*DW-1:0] w, input int r, input int c);
      return $signed({{(AW-DW){1'b0}}, w[((r-1)*5+(c-1))*DW +: DW]});
   endfunction

   function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] s);
      logic signed [AW-1:0] t;
      t = s + RND_OFS;
      return t >>> 4;
   endfunction

   // Result is {sat, pix}.
   function automatic logic [DW:0] clip(input logic signed [AW-1:0] r);
      if (r[AW-1])          return {1'b1, {DW{1'b0}}};
      else if (r > PIX_MAX) return {1'b1, PIX_MAX[DW-1:0]};
      else                  return {1'b0, r[DW-1:0]};
   endfunction

   logic                 en;
   logic                 vld_p1, vld_p2, vld_p3;
   logic [1:0]           mode_p1;
   logic signed [AW-1:0] x_p1, c_p1, f_p1, h_p1, v_p1, hf_p1, vf_p1, ctr_p1;
   logic signed [AW-1:0] h_d, v_d, hf_d, vf_d, x_d;
   logic signed [AW-1:0] s_d, s_p2;

   // The whole pipeline moves as one; bubbles are kept, never squeezed out.
   assign en        = !vld_p3 || out_ready;
   assign in_ready  = en;
   assign out_valid = vld_p3;

   always_comb begin
      h_d  = tap(in_win, 3, 2) + tap(in_win, 3, 4);
      v_d  = tap(in_win, 2, 3) + tap(in_win, 4, 3);
      hf_d = tap(in_win, 3, 1) + tap(in_win, 3, 5);
      vf_d = tap(in_win, 1, 3) + tap(in_win, 5, 3);
      x_d  = tap(in_win, 2, 2) + tap(in_win, 2, 4) + tap(in_win, 4, 2) + tap(in_win, 4, 4);
   end

   always_comb begin
      s_d = '0;
      case (mode_p1)
         2'd0:    s_d = (x_p1 <<< 2) + (ctr_p1 <<< 3) + (ctr_p1 <<< 2) - (f_p1 <<< 1) - f_p1;
         2'd1:    s_d = (c_p1 <<< 2) + (ctr_p1 <<< 3) - (f_p1 <<< 1);
         2'd2:    s_d = (h_p1 <<< 3) + (ctr_p1 <<< 3) + (ctr_p1 <<< 1)
                        - ((hf_p1 + x_p1) <<< 1) + vf_p1;
         default: s_d = (v_p1 <<< 3) + (ctr_p1 <<< 3) + (ctr_p1 <<< 1)
                        - ((vf_p1 + x_p1) <<< 1) + hf_p1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         vld_p3  <= 1'b0;
         mode_p1 <= '0;
         x_p1    <= '0;
         c_p1    <= '0;
         f_p1    <= '0;
         h_p1    <= '0;
         v_p1    <= '0;
         hf_p1   <= '0;
         vf_p1   <= '0;
         ctr_p1  <= '0;
         s_p2    <= '0;
         out_pix <= '0;
         out_sat <= 1'b0;
      end else if (en) begin
         // Stage 1: group and pair sums
         vld_p1  <= in_valid;
         mode_p1 <= in_mode;
         x_p1    <= x_d;
         c_p1    <= h_d + v_d;
         f_p1    <= hf_d + vf_d;
         h_p1    <= h_d;
         v_p1    <= v_d;
         hf_p1   <= hf_d;
         vf_p1   <= vf_d;
         ctr_p1  <= tap(in_win, 3, 3);
         // Stage 2: full-precision weighted total for the selected kernel
         vld_p2  <= vld_p1;
         s_p2    <= s_d;
         // Stage 3: single rounding, shift, clip
         vld_p3  <= vld_p2;
         {out_sat, out_pix} <= clip(round_shift(s_p2));
      end
   end
endmodule

// File: tb/tb_rb_interp_5x5_pipe.sv
// Directed bench for rb_interp_5x5_pipe: reset, kernel modes, clipping, rounding, stalls, mid-flight reset.
`timescale 1ns/1ps
module tb_rb_interp_5x5_pipe;
   localparam int DW = 10;
   localparam int M  = 1023;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b1;
   logic [1:0]       in_mode = '0;
   logic [25*DW-1:0] in_win = '0;
   logic             in_ready, out_valid, out_sat;
   logic [DW-1:0]    out_pix;
   logic             in_ready_f, out_valid_f, out_sat_f;
   logic [DW-1:0]    out_pix_f;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rb_interp_5x5_pipe #(.DW(DW), .ROUND(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_win(in_win), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_sat(out_sat)
   );

   rb_interp_5x5_pipe #(.DW(DW), .ROUND(0)) dut_floor (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f), .in_mode(in_mode),
      .in_win(in_win), .out_valid(out_valid_f), .out_ready(out_ready), .out_pix(out_pix_f),
      .out_sat(out_sat_f)
   );

   function automatic logic [25*DW-1:0] put(input logic [25*DW-1:0] w, input int r, input int c, input int v);
      logic [25*DW-1:0] t;
      t = w;
      t[((r-1)*5+(c-1))*DW +: DW] = v[DW-1:0];
      return t;
   endfunction

   function automatic int get(input logic [25*DW-1:0] w, input int r, input int c);
      return int'(w[((r-1)*5+(c-1))*DW +: DW]);
   endfunction

   function automatic logic [25*DW-1:0] flat(input int v);
      logic [25*DW-1:0] t;
      t = '0;
      for (int r = 1; r <= 5; r++)
         for (int c = 1; c <= 5; c++) t = put(t, r, c, v);
      return t;
   endfunction

   // Reference written straight from the kernel equations, round-half-up; result {sat, pix}.
   function automatic logic [DW:0] model(input int mode, input logic [25*DW-1:0] w);
      int x, cr, f, s, r;
      x  = get(w,2,2) + get(w,2,4) + get(w,4,2) + get(w,4,4);
      cr = get(w,2,3) + get(w,3,2) + get(w,3,4) + get(w,4,3);
      f  = get(w,1,3) + get(w,3,1) + get(w,3,5) + get(w,5,3);
      case (mode)
         0:       s = 4*x + 12*get(w,3,3) - 3*f;
         1:       s = 4*cr + 8*get(w,3,3) - 2*f;
         2:       s = 8*(get(w,3,2)+get(w,3,4)) + 10*get(w,3,3)
                      - 2*(get(w,3,1)+get(w,3,5)+x) + get(w,1,3) + get(w,5,3);
         default: s = 8*(get(w,2,3)+get(w,4,3)) + 10*get(w,3,3)
                      - 2*(get(w,1,3)+get(w,5,3)+x) + get(w,3,1) + get(w,3,5);
      endcase
      r = (s + 8) >>> 4;
      if (r < 0)      return {1'b1, {DW{1'b0}}};
      else if (r > M) return {1'b1, {DW{1'b1}}};
      else            return {1'b0, r[DW-1:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one window with out_ready high, returns out_valid after 2 and 3 edges plus the 3rd-edge result.
   task automatic send_one(input int mode, input logic [25*DW-1:0] w, output logic v2, output logic v3,
                           output logic [DW-1:0] p3, output logic s3, output logic [DW-1:0] pf);
      out_ready = 1'b1;
      in_mode   = mode[1:0];
      in_win    = w;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      in_win   = '0;
      step();
      v2 = out_valid;
      step();
      v3 = out_valid;
      p3 = out_pix;
      s3 = out_sat;
      pf = out_pix_f;
      step();
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({out_valid, out_pix, out_sat} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got valid=%0b pix=%0d sat=%0b, want 0/0/0", out_valid, out_pix, out_sat);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_flat();
      logic v2, v3, s3;
      logic [DW-1:0] p3, pf;
      for (int m = 0; m < 4; m++) begin
         send_one(m, flat(512), v2, v3, p3, s3, pf);
         vectors++;
         if (v2 !== 1'b0 || v3 !== 1'b1) begin
            miscompares++;
            $display("FAIL flat_latency m%0d: got valid@2=%0b valid@3=%0b, want 0/1", m, v2, v3);
         end
         vectors++;
         if (p3 !== 10'd512 || s3 !== 1'b0) begin
            miscompares++;
            $display("FAIL flat_value m%0d: got pix=%0d sat=%0b, want 512/0", m, p3, s3);
         end
      end
   endtask

   task automatic test_saturation();
      logic v2, v3, s3;
      logic [DW-1:0] p3, pf;
      logic [25*DW-1:0] w;
      w = put(put(put(put(put('0, 3,3, M), 2,2, M), 2,4, M), 4,2, M), 4,4, M);
      send_one(0, w, v2, v3, p3, s3, pf);
      vectors++;
      if (v3 !== 1'b1 || p3 !== 10'd1023 || s3 !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_high: got valid=%0b pix=%0d sat=%0b, want 1/1023/1", v3, p3, s3);
      end
      w = put(put(put(put('0, 1,3, M), 3,1, M), 3,5, M), 5,3, M);
      send_one(0, w, v2, v3, p3, s3, pf);
      vectors++;
      if (v3 !== 1'b1 || p3 !== 10'd0 || s3 !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_low: got valid=%0b pix=%0d sat=%0b, want 1/0/1", v3, p3, s3);
      end
   endtask

   task automatic test_rounding();
      logic v2, v3, s3;
      logic [DW-1:0] p3, pf;
      send_one(1, put('0, 3, 3, 1), v2, v3, p3, s3, pf);
      vectors++;
      if (p3 !== 10'd1 || s3 !== 1'b0) begin
         miscompares++;
         $display("FAIL round_half_up: got pix=%0d sat=%0b, want 1/0", p3, s3);
      end
      vectors++;
      if (pf !== 10'd0 || out_sat_f !== 1'b0) begin
         miscompares++;
         $display("FAIL round_floor: got pix=%0d sat=%0b, want 0/0", pf, out_sat_f);
      end
   endtask

   task automatic test_back_to_back();
      logic [25*DW-1:0] win_q [8];
      logic [1:0]       mode_q [8];
      logic [DW:0]      exp_q [8];
      logic [DW-1:0]    held_p;
      logic             held_s, stalled;
      int sent, got, cyc;
      for (int k = 0; k < 8; k++) begin
         win_q[k] = '0;
         for (int r = 1; r <= 5; r++)
            for (int c = 1; c <= 5; c++)
               win_q[k] = put(win_q[k], r, c, (r*131 + c*57 + k*211 + r*c*k*13) % 1024);
         mode_q[k] = 2'(k % 4);
      end
      win_q[4] = put(put(put(put('0, 1,3, M), 3,1, M), 3,5, M), 5,3, M);
      for (int k = 0; k < 8; k++) exp_q[k] = model(int'(mode_q[k]), win_q[k]);
      sent = 0; got = 0; cyc = 0; stalled = 1'b0; held_p = '0; held_s = 1'b0;
      while (got < 8 && cyc < 200) begin
         out_ready = (cyc % 2 == 0);
         if (sent < 8) begin
            in_valid = 1'b1;
            in_mode  = mode_q[sent];
            in_win   = win_q[sent];
         end else begin
            in_valid = 1'b0;
            in_win   = '0;
         end
         #1;
         if (stalled) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pix !== held_p || out_sat !== held_s) begin
               miscompares++;
               $display("FAIL stall_hold #%0d: got valid=%0b pix=%0d sat=%0b, want 1/%0d/%0b",
                        got, out_valid, out_pix, out_sat, held_p, held_s);
            end
         end
         stalled = 1'b0;
         if (out_valid && !out_ready) begin
            vectors++;
            if (in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL stall_in_ready: got %0b, want 0", in_ready);
            end
            stalled = 1'b1;
            held_p  = out_pix;
            held_s  = out_sat;
         end
         if (out_valid && out_ready) begin
            vectors++;
            if ({out_sat, out_pix} !== exp_q[got]) begin
               miscompares++;
               $display("FAIL stream_out #%0d: got pix=%0d sat=%0b, want %0d/%0b",
                        got, out_pix, out_sat, exp_q[got][DW-1:0], exp_q[got][DW]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      vectors++;
      if (got != 8) begin
         miscompares++;
         $display("FAIL stream_timeout: got %0d outputs, want 8", got);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_extra: got out_valid=%0b, want 0 (cycle %0d after drain)", out_valid, i);
         end
      end
   endtask

   task automatic test_reset_midflight();
      logic v2, v3, s3;
      logic [DW-1:0] p3, pf;
      logic [DW:0]   exp_v;
      logic [25*DW-1:0] w;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_mode  = 2'(i);
         in_win   = flat(100 + 100*i);
         step();
      end
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_pix !== 10'd100) begin
         miscompares++;
         $display("FAIL pre_reset: got valid=%0b pix=%0d, want 1/100", out_valid, out_pix);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_pix !== 10'd0 || out_sat !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got valid=%0b pix=%0d sat=%0b, want 0/0/0", out_valid, out_pix, out_sat);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_output cycle %0d: got out_valid=%0b, want 0", i, out_valid);
         end
      end
      w = put(put(put(put(put('0, 3,3, 400), 2,3, 300), 3,2, 200), 3,4, 100), 1,3, 50);
      exp_v = model(1, w);
      send_one(1, w, v2, v3, p3, s3, pf);
      vectors++;
      if (v2 !== 1'b0 || v3 !== 1'b1 || {s3, p3} !== exp_v) begin
         miscompares++;
         $display("FAIL post_reset_window: got valid@2=%0b valid@3=%0b pix=%0d sat=%0b, want 0/1/%0d/%0b",
                  v2, v3, p3, s3, exp_v[DW-1:0], exp_v[DW]);
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
